// File: rtl/move_sequencer.sv
// move_sequencer: register-programmed stepper move queue.
// Moves ({dir, steps}) are pushed through a small command FIFO and run one at
// a time. Each move clears the external step counter, loads its limit, enables
// the motor until the counter reports done, and then settles for a fixed idle
// time. A RUN watchdog raises a sticky fault and flushes the queue.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   addr/cs/wr/rd     register bus; data_in write data, data_out read data (comb)
//   enable, motor_dir motor enable, direction (0 = CW, 1 = CCW)
//   limit_out         step limit presented to the counter
//   load_limit        one-clock limit load pulse
//   cnt_clr           one-clock counter clear pulse
//   done              counter limit reached (level)
//   busy              sequencer not idle
//   irq               completion pending or fault
module move_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SETTLE_CYCLES  = 100,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        enable,
  output logic        motor_dir,
  output logic [15:0] limit_out,
  output logic        load_limit,
  output logic        cnt_clr,
  input  logic        done,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned EW = 17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_RUN    = 3'd3,
    S_SETTLE = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      steps_lo, steps_hi;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   fifo_cnt;
  logic [RW-1:0]   run_cnt;
  logic [SW-1:0]   settle_cnt;
  logic [7:0]      cmp_cnt;
  logic            fault, overflow, cmp_pend;

  logic            fifo_full, fifo_empty;
  logic            cmd_wr, abort, clr_flags, push_req, push_ok, push_drop;
  logic            pop, go_load, complete, timeout, flush;
  logic [EW-1:0]   head;

  // Register decode; an abort in the same write discards the push.
  assign cmd_wr     = cs & wr & (addr == 16'h0002);
  assign abort      = cmd_wr & data_in[2];
  assign clr_flags  = cmd_wr & data_in[3];
  assign push_req   = cmd_wr & data_in[1] & ~data_in[2];

  assign fifo_full  = (fifo_cnt == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same clock.
  assign push_ok    = push_req & (state_q != S_FAULT) & ~timeout & (~fifo_full | pop);
  assign push_drop  = push_req & ~push_ok;
  assign flush      = abort | timeout;

  assign busy       = (state_q != S_IDLE);
  assign irq        = cmp_pend | fault;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and sequencing strobes.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    go_load  = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_d = S_CLEAR;
            pop     = 1'b1;
          end
        end
        S_CLEAR: begin
          // A zero-length move completes without ever enabling the motor.
          if (limit_out == '0) begin
            state_d  = S_IDLE;
            complete = 1'b1;
          end else begin
            state_d = S_LOAD;
            go_load = 1'b1;
          end
        end
        S_LOAD: state_d = S_RUN;
        S_RUN: begin
          // done is not trusted in the first RUN clock (counter just loaded).
          if ((run_cnt != '0) && done) begin
            state_d  = S_SETTLE;
            complete = 1'b1;
          end else if (run_cnt == RW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_FAULT;
            timeout = 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_d = S_IDLE;
        end
        S_FAULT: begin
          if (clr_flags) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Command FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {data_in[0], steps_hi, steps_lo};
  end

  // Command FIFO pointers and level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)     rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + LW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - LW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Staging registers, motor outputs, counters and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_lo   <= '0;
      steps_hi   <= '0;
      limit_out  <= '0;
      motor_dir  <= 1'b0;
      cnt_clr    <= 1'b0;
      load_limit <= 1'b0;
      enable     <= 1'b0;
      run_cnt    <= '0;
      settle_cnt <= '0;
      cmp_cnt    <= '0;
      fault      <= 1'b0;
      overflow   <= 1'b0;
      cmp_pend   <= 1'b0;
    end else begin
      if (cs && wr && addr == 16'h0000) steps_lo <= data_in;
      if (cs && wr && addr == 16'h0001) steps_hi <= data_in;
      // Direction only changes while the motor is disabled (IDLE -> CLEAR).
      if (pop) begin
        limit_out <= head[15:0];
        motor_dir <= head[16];
      end
      cnt_clr    <= pop;
      load_limit <= go_load;
      enable     <= (state_d == S_RUN);
      if (state_q == S_RUN) run_cnt <= run_cnt + RW'(1);
      else                  run_cnt <= '0;
      if (state_q == S_SETTLE) settle_cnt <= settle_cnt + SW'(1);
      else                     settle_cnt <= '0;
      if (complete) cmp_cnt <= cmp_cnt + 8'd1;
      // Events raised in the same clock as a clear take precedence.
      if (clr_flags) begin
        fault    <= 1'b0;
        overflow <= 1'b0;
        cmp_pend <= 1'b0;
      end
      if (complete)  cmp_pend <= 1'b1;
      if (timeout)   fault    <= 1'b1;
      if (push_drop) overflow <= 1'b1;
    end
  end

  // Combinational register read port.
  always_comb begin
    data_out = '0;
    if (cs && rd) begin
      case (addr)
        16'h0000: data_out = {fault, overflow, cmp_pend, fifo_full, fifo_empty, 3'(state_q)};
        16'h0001: data_out = 8'(fifo_cnt);
        16'h0002: data_out = cmp_cnt;
        16'h0003: data_out = limit_out[7:0];
        16'h0004: data_out = limit_out[15:8];
        default:  data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed self-checking bench for move_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_move_sequencer;

  localparam int unsigned SETTLE  = 100;
  localparam int unsigned TIMEOUT = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        enable, motor_dir, load_limit, cnt_clr, busy, irq, done;
  logic [15:0] limit_out;

  logic        auto_done = 1'b0, auto_val = 1'b0, man_done = 1'b0;
  assign done = auto_done ? auto_val : man_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state (reset whenever rst_n is seen low).
  int   cyc = 0;
  int   n_clr = 0, n_load = 0, n_fall = 0, n_en = 0, dir_viol = 0, en_run = 0;
  int   t_clr1 = 0, t_fall0 = 0;
  logic dir_clr0 = 1'b0, dir_clr1 = 1'b0, prev_en = 1'b0, prev_dir = 1'b0;

  move_sequencer #(
    .FIFO_DEPTH    (4),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .cs        (cs),
    .wr        (wr),
    .rd        (rd),
    .data_in   (data_in),
    .data_out  (data_out),
    .enable    (enable),
    .motor_dir (motor_dir),
    .limit_out (limit_out),
    .load_limit(load_limit),
    .cnt_clr   (cnt_clr),
    .done      (done),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Pulse/edge monitor and a simple step counter: done after 4 enabled clocks.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      n_clr = 0; n_load = 0; n_fall = 0; n_en = 0; dir_viol = 0; en_run = 0;
      prev_en = 1'b0; prev_dir = 1'b0;
    end else begin
      if (cnt_clr) begin
        if (n_clr == 0) dir_clr0 = motor_dir;
        if (n_clr == 1) begin t_clr1 = cyc; dir_clr1 = motor_dir; end
        n_clr = n_clr + 1;
      end
      if (load_limit) n_load = n_load + 1;
      if (enable) n_en = n_en + 1;
      if (prev_en && !enable) begin
        if (n_fall == 0) t_fall0 = cyc;
        n_fall = n_fall + 1;
      end
      if (prev_en && enable && (motor_dir != prev_dir)) dir_viol = dir_viol + 1;
      en_run   = enable ? en_run + 1 : 0;
      prev_en  = enable;
      prev_dir = motor_dir;
    end
    auto_val = (en_run >= 4);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [7:0] d);
    addr = a; cs = 1'b1; rd = 1'b1;
    #1;
    d = data_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    auto_done = 1'b0; man_done = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int n, k;

    // Reset state.
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_enable", 32'(enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_limit", 32'(limit_out), 0);
    rd_reg(16'h0000, d);
    check("rst_status", 32'(d), 32'h08);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 20-step CW move with done asserted early (first RUN clock ignores it).
    wr_reg(16'h0000, 8'd20);
    wr_reg(16'h0001, 8'd0);
    wr_reg(16'h0002, 8'h02);
    rd_reg(16'h0001, d);
    check("m1_level", 32'(d), 1);
    @(negedge clk);
    check("m1_cnt_clr", 32'(cnt_clr), 1);
    check("m1_clr_limit", 32'(limit_out), 20);
    check("m1_clr_load", 32'(load_limit), 0);
    man_done = 1'b1;
    @(negedge clk);
    check("m1_load", 32'(load_limit), 1);
    check("m1_load_limit", 32'(limit_out), 20);
    check("m1_load_en", 32'(enable), 0);
    @(negedge clk);
    check("m1_run_en", 32'(enable), 1);
    check("m1_run_load", 32'(load_limit), 0);
    @(negedge clk);
    check("m1_first_done_ignored", 32'(enable), 1);
    @(negedge clk);
    man_done = 1'b0;
    check("m1_settle_en", 32'(enable), 0);
    check("m1_irq", 32'(irq), 1);
    rd_reg(16'h0002, d);
    check("m1_count", 32'(d), 1);
    rd_reg(16'h0000, d);
    check("m1_status_settle", 32'(d), 32'h2C);
    n = 0;
    while (busy && n < 300) begin n++; @(negedge clk); end
    check("m1_settle_len", 32'(n), SETTLE);
    wr_reg(16'h0002, 8'h08);
    check("m1_irq_cleared", 32'(irq), 0);

    // Two back-to-back moves, CW then CCW.
    do_reset();
    auto_done = 1'b1;
    wr_reg(16'h0000, 8'd20);
    wr_reg(16'h0001, 8'd0);
    wr_reg(16'h0002, 8'h02);
    wr_reg(16'h0002, 8'h03);
    k = 0;
    while (!(n_fall >= 2 && !busy) && k < 2000) begin @(negedge clk); #2; k++; end
    check("m2_wait", 32'(k < 2000), 1);
    check("m2_gap", 32'(t_clr1 - t_fall0), SETTLE + 1);
    check("m2_dir0", 32'(dir_clr0), 0);
    check("m2_dir1", 32'(dir_clr1), 1);
    check("m2_dir_viol", 32'(dir_viol), 0);
    check("m2_loads", 32'(n_load), 2);
    rd_reg(16'h0002, d);
    check("m2_count", 32'(d), 2);
    @(negedge clk);

    // Queue fill while the head runs, overflow, push+pop, then abort.
    do_reset();
    wr_reg(16'h0000, 8'd10);
    wr_reg(16'h0001, 8'd0);
    wr_reg(16'h0002, 8'h02);
    wr_reg(16'h0002, 8'h02);
    rd_reg(16'h0001, d);
    check("q_pushpop_level", 32'(d), 1);
    wr_reg(16'h0002, 8'h02);
    wr_reg(16'h0002, 8'h02);
    wr_reg(16'h0002, 8'h02);
    rd_reg(16'h0000, d);
    check("q_full_no_ovf", 32'(d), 32'h13);
    wr_reg(16'h0002, 8'h02);
    rd_reg(16'h0000, d);
    check("q_overflow", 32'(d), 32'h53);
    rd_reg(16'h0001, d);
    check("q_level_full", 32'(d), 4);
    wr_reg(16'h0002, 8'h06);
    check("ab_enable", 32'(enable), 0);
    check("ab_busy", 32'(busy), 0);
    rd_reg(16'h0000, d);
    check("ab_status", 32'(d), 32'h48);
    rd_reg(16'h0002, d);
    check("ab_count", 32'(d), 0);
    @(negedge clk);
    check("ab_push_discarded", 32'(busy), 0);

    // Watchdog timeout with a 0x1234-step move and one queued command.
    do_reset();
    wr_reg(16'h0000, 8'h34);
    wr_reg(16'h0001, 8'h12);
    wr_reg(16'h0002, 8'h02);
    wr_reg(16'h0002, 8'h02);
    check("to_limit", 32'(limit_out), 32'h1234);
    rd_reg(16'h0003, d);
    check("to_rd_lo", 32'(d), 32'h34);
    rd_reg(16'h0004, d);
    check("to_rd_hi", 32'(d), 32'h12);
    rd_reg(16'h0005, d);
    check("to_rd_unmapped", 32'(d), 0);
    addr = 16'h0003; rd = 1'b1; #1;
    check("to_rd_no_cs", 32'(data_out), 0);
    rd = 1'b0;
    k = 0;
    while (!enable && k < 20) begin @(negedge clk); k++; end
    n = 0;
    while (enable && n < 1000) begin n++; @(negedge clk); end
    check("to_run_len", 32'(n), TIMEOUT);
    check("to_irq", 32'(irq), 1);
    rd_reg(16'h0000, d);
    check("to_status", 32'(d), 32'h8D);
    wr_reg(16'h0002, 8'h02);
    rd_reg(16'h0000, d);
    check("to_push_in_fault", 32'(d), 32'hCD);
    wr_reg(16'h0002, 8'h08);
    rd_reg(16'h0000, d);
    check("to_cleared", 32'(d), 32'h08);
    check("to_irq_cleared", 32'(irq), 0);

    // Zero-step command.
    do_reset();
    wr_reg(16'h0000, 8'd0);
    wr_reg(16'h0001, 8'd0);
    wr_reg(16'h0002, 8'h02);
    repeat (6) @(negedge clk);
    #2;
    check("z_clr", 32'(n_clr), 1);
    check("z_load", 32'(n_load), 0);
    check("z_enable", 32'(n_en), 0);
    rd_reg(16'h0002, d);
    check("z_count", 32'(d), 1);
    check("z_irq", 32'(irq), 1);

    // Asynchronous reset in the middle of a CCW move with a command queued.
    do_reset();
    wr_reg(16'h0000, 8'd10);
    wr_reg(16'h0001, 8'd0);
    wr_reg(16'h0002, 8'h03);
    wr_reg(16'h0002, 8'h03);
    k = 0;
    while (!enable && k < 20) begin @(negedge clk); k++; end
    check("rr_running", 32'(enable), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_enable", 32'(enable), 0);
    check("rr_dir", 32'(motor_dir), 0);
    check("rr_limit", 32'(limit_out), 0);
    check("rr_pulses", 32'({load_limit, cnt_clr}), 0);
    check("rr_busy_irq", 32'({busy, irq}), 0);
    rd_reg(16'h0000, d);
    check("rr_status", 32'(d), 32'h08);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
